// File: rtl/sync_fifo_pkg.sv
// Shared widths and drain-engine state encoding for the syn_fifo read-side engine.
package sync_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } drain_state_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// Purpose: 2-entry register buffer with push/pop/clear, exposing head and occupancy.
// Latency: push visible at head the cycle after it is written.
// Backpressure: caller must not push when full or pop when empty.
module fifo_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         clear,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) slot0_d = push_dat;
                    else               slot1_d = push_dat;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word lands; count is unchanged.
                    if (cnt_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_dat;
                    end else begin
                        slot0_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head  = slot0_q;
    assign count = cnt_q;
endmodule

// File: rtl/sync_fifo_drain.sv
// Purpose: pops syn_fifo and re-presents words on a valid/ready stream via a 2-entry skid buffer.
// Latency: pop in cycle N gives m_valid in cycle N+2; 1 word/cycle sustained.
// Backpressure: pops only while a buffer slot is reserved for every in-flight word; flush discards.
module sync_fifo_drain
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [1:0]           buf_cnt;
    logic [2:0]           occ;
    logic [2:0]           cnt_nxt;
    logic                 deq;
    logic                 pop;
    logic                 push;
    drain_state_t         state_q;

    fifo_skid_buf #(.W(DATA_WIDTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (fifo_rdata),
        .pop      (deq),
        .clear    (flush),
        .head     (m_data),
        .count    (buf_cnt)
    );

    always_comb begin
        deq  = m_valid && m_ready;
        occ  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, deq};
        // Gating with rst keeps the pop request low while reset is held.
        pop  = rst && !fifo_empty && !flush && (occ < 3'd2);
        push = inflight_q && !flush;
        inflight_d = pop;
        rd_count_d = rd_count_q + CNT_WIDTH'(pop);
        cnt_nxt    = flush ? 3'd0 : ({1'b0, buf_cnt} + {2'b00, push} - {2'b00, deq});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (flush || (cnt_nxt == 3'd0 && !pop)) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pop) state_q <= ACTIVE;
                ACTIVE:  if (buf_cnt == 2'd2 && !m_ready) state_q <= STALL;
                STALL:   if (deq) state_q <= ACTIVE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en = pop;
    assign m_valid    = (buf_cnt != 2'd0);
    assign rd_count   = rd_count_q;
    assign busy       = m_valid || inflight_q;
endmodule

// File: tb/tb_sync_fifo_drain.sv
// Drives a queue-modelled 16-deep syn_fifo into the drain engine and checks the stream against a scoreboard.
module tb_sync_fifo_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        flush;
    logic [15:0] rd_count;
    logic        busy;
    logic        wr_req;
    logic [7:0]  wr_data;

    typedef struct {
        int         e;
        logic [7:0] v;
    } ent_t;

    logic [7:0] fq[$];
    ent_t       exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_e[$];
    int         ecnt = 0;
    int         pops = 0;
    int         first_pop = -1;
    int         first_vld = -1;
    int         n_checks = 0;
    int         n_errs = 0;
    bit         wr_done;

    sync_fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .flush      (flush),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model plus scoreboard: a word popped at edge E becomes visible after edge E+1.
    always @(posedge clk) begin
        bit         full;
        bit         vis_p;
        ent_t       en;
        logic [7:0] w;
        full  = (fq.size() >= 16);
        vis_p = (exp_q.size() > 0) && (exp_q[0].e <= ecnt - 2);
        if (!rst) begin
            exp_q.delete();
            pops = 0;
        end else begin
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                rx_e.push_back(ecnt);
            end
            if (vis_p && m_ready) en = exp_q.pop_front();
            if (flush) exp_q.delete();
            if (fifo_rd_en && fq.size() > 0) begin
                w = fq.pop_front();
                fifo_rdata <= w;
                en.e = ecnt;
                en.v = w;
                exp_q.push_back(en);
                pops++;
                if (first_pop < 0) first_pop = ecnt;
            end
        end
        if (wr_req && !full) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
        ecnt++;
    end

    always @(negedge clk) begin
        bit vis;
        bit exp_rd;
        int occ;
        if (rst) begin
            vis = (exp_q.size() > 0) && (exp_q[0].e <= ecnt - 2);
            chk("m_valid", 32'(m_valid), 32'(vis));
            if (vis) chk("m_data", 32'(m_data), 32'(exp_q[0].v));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            occ    = exp_q.size() - ((vis && m_ready) ? 1 : 0);
            exp_rd = (fq.size() != 0) && !flush && (occ < 2);
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            chk("rd_count", 32'(rd_count), 32'(pops % 65536));
            if (first_vld < 0 && m_valid) first_vld = ecnt;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_data = start + 8'(i);
            cyc(1);
        end
        wr_req = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int lim, input string nm);
        int c = 0;
        while (rx_q.size() < target && c < lim) begin cyc(1); c++; end
        chk(nm, 32'(rx_q.size()), 32'(target));
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int c = 0;
        while ((fq.size() != 0 || busy) && c < lim) begin cyc(1); c++; end
        chk(nm, 32'(fq.size() == 0 && !busy), 32'd1);
    endtask

    task automatic check_rx(input int base, input logic [7:0] start, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size()) chk(nm, 32'(rx_q[base + i]), 32'(start + 8'(i)));
            else chk(nm, 32'hFFFF_FFFF, 32'(start + 8'(i)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rxb, pb, nrd;
        rst = 1'b0; wr_req = 1'b0; wr_data = 8'h00; m_ready = 1'b0; flush = 1'b0;
        cyc(1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Stream 16 words with the consumer always ready.
        m_ready = 1'b1; rxb = rx_q.size(); first_pop = -1; first_vld = -1;
        write_seq(8'h01, 16);
        wait_rx(rxb + 16, 100, "stream_count");
        check_rx(rxb, 8'h01, 16, "stream_order");
        chk("stream_latency", 32'(first_vld - first_pop), 32'd2);
        if (rx_q.size() >= rxb + 16) chk("stream_rate", 32'(rx_e[rxb + 15] - rx_e[rxb]), 32'd15);
        chk("stream_rd_count", 32'(rd_count), 32'd16);
        wait_idle(50, "stream_idle");

        // Backpressure: consumer stalled with 16 words queued.
        m_ready = 1'b0; rxb = rx_q.size();
        write_seq(8'h01, 16);
        cyc(10);
        chk("bp_rd_count", 32'(rd_count), 32'd18);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h01);
        chk("bp_fifo_level", 32'(fq.size()), 32'd14);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        wait_rx(rxb + 16, 100, "bp_count");
        check_rx(rxb, 8'h01, 16, "bp_order");
        wait_idle(50, "bp_idle");

        // Empty FIFO: the engine must never request a pop.
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (fifo_rd_en) nrd++;
            @(posedge clk); #1;
        end
        chk("empty_rd_en", 32'(nrd), 32'd0);

        // Flush with one word buffered and one in flight after a single delivery.
        m_ready = 1'b0; rxb = rx_q.size(); pb = pops;
        write_seq(8'h21, 8);
        cyc(12);
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0; flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_rd_count", 32'(rd_count), 32'((pb + 3) % 65536));
        m_ready = 1'b1;
        wait_rx(rxb + 2, 50, "flush_count");
        if (rx_q.size() >= rxb + 2) begin
            chk("flush_first", 32'(rx_q[rxb]), 32'h21);
            chk("flush_next", 32'(rx_q[rxb + 1]), 32'h24);
        end
        wait_idle(50, "flush_idle");

        // Reset mid-stream with two words buffered.
        m_ready = 1'b0;
        write_seq(8'h31, 5);
        cyc(10);
        rst = 1'b0;
        #1;
        chk("mrst_m_valid", 32'(m_valid), 32'd0);
        chk("mrst_m_data", 32'(m_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rd_count", 32'(rd_count), 32'd0);
        chk("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
        cyc(2);
        rst = 1'b1; m_ready = 1'b1; rxb = rx_q.size();
        wait_rx(rxb + 3, 50, "mrst_count");
        check_rx(rxb, 8'h33, 3, "mrst_order");
        wait_idle(50, "mrst_idle");
        chk("mrst_pops", 32'(rd_count), 32'd3);

        // Random writer and consumer delays.
        rxb = rx_q.size(); pb = pops; wr_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    int g = 0;
                    cyc($urandom_range(1, 10));
                    while (fq.size() >= 16 && g < 2000) begin cyc(1); g++; end
                    wr_req  = 1'b1;
                    wr_data = 8'($urandom);
                    cyc(1);
                    wr_req = 1'b0;
                end
                wr_done = 1'b1;
            end
            begin
                while (!wr_done) begin
                    m_ready = 1'b1;
                    cyc($urandom_range(1, 10));
                    m_ready = 1'b0;
                    cyc($urandom_range(1, 10));
                end
            end
        join
        m_ready = 1'b1;
        wait_idle(200, "rand_idle");
        chk("rand_delivered", 32'(rx_q.size() - rxb), 32'd150);
        chk("rand_rd_count", 32'(rd_count), 32'((pb + 150) % 65536));
        chk("rand_pops_eq_deliv", 32'(pops - pb), 32'(rx_q.size() - rxb));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
